// File: rtl/orient_kp_scheduler_pkg.sv
// Shared constants and record layouts for the orientation keypoint scheduler.
// - ORI_LAT   : cycles from a column on o_col to its cos/sin from the unit
// - tag_t     : {v, x, y} keypoint tag carried through the latency-matching delay line
// - entry_t   : {x, y, cos, sin} output FIFO record (44 bits)
package orient_kp_scheduler_pkg;

  localparam int ORI_LAT    = 7;
  localparam int COORD_W    = 10;
  localparam int TRIG_W     = 12;
  localparam int COL_W      = 56;
  localparam int FIFO_DEPTH = 4;
  localparam int DROP_W     = 16;
  localparam int RUN_W      = 3;
  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;

  // A full 7x7 window needs 7 consecutive valid columns and a centre 3 away from the edges.
  localparam logic [RUN_W-1:0]   RUN_FULL   = 3'd7;
  localparam logic [COORD_W-1:0] WIN_MIN    = 10'd6;
  localparam logic [COORD_W-1:0] WIN_HALF   = 10'd3;

  typedef struct packed {
    logic               v;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } tag_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [TRIG_W-1:0]  cos_v;
    logic [TRIG_W-1:0]  sin_v;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  // Saturating run-length increment.
  function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] run);
    if (run == RUN_FULL) begin
      return RUN_FULL;
    end else begin
      return run + 3'd1;
    end
  endfunction

endpackage

// File: rtl/orient_kp_scheduler_if.sv
// Bundle of the scheduler's stream, orientation-unit and consumer signals.
// - slave  : the scheduler side (takes i_*, drives o_*)
// - master : the environment side (drives i_*, takes o_*)
// Signals: i_valid/i_sof/i_col/i_kp column stream, o_col to the unit, i_cos/i_sin
// from the unit, o_valid/i_ready pop handshake, o_x/o_y/o_cos/o_sin FIFO head,
// o_drop_cnt saturating count of keypoints lost to a full FIFO.
interface orient_kp_scheduler_if;
  import orient_kp_scheduler_pkg::*;

  logic                      i_valid;
  logic                      i_sof;
  logic [COL_W-1:0]          i_col;
  logic                      i_kp;
  logic [COL_W-1:0]          o_col;
  logic signed [TRIG_W-1:0]  i_cos;
  logic signed [TRIG_W-1:0]  i_sin;
  logic                      o_valid;
  logic                      i_ready;
  logic [COORD_W-1:0]        o_x;
  logic [COORD_W-1:0]        o_y;
  logic signed [TRIG_W-1:0]  o_cos;
  logic signed [TRIG_W-1:0]  o_sin;
  logic [DROP_W-1:0]         o_drop_cnt;

  modport slave (
    input  i_valid, i_sof, i_col, i_kp, i_cos, i_sin, i_ready,
    output o_col, o_valid, o_x, o_y, o_cos, o_sin, o_drop_cnt
  );

  modport master (
    output i_valid, i_sof, i_col, i_kp, i_cos, i_sin, i_ready,
    input  o_col, o_valid, o_x, o_y, o_cos, o_sin, o_drop_cnt
  );

endinterface

// File: rtl/orient_kp_scheduler_kp_sync_fifo.sv
// Small first-word-fall-through synchronous FIFO.
// Ports: i_clk, i_rst_n (async active-low), i_push/i_data write side,
// i_pop read side, o_data = head entry, o_full, o_empty.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module kp_sync_fifo #(
  parameter int W     = 44,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push_s;
  logic          do_pop_s;

  assign o_empty   = (cnt_q == '0);
  assign o_full    = (cnt_q == CNT_FULL);
  assign do_pop_s  = i_pop & ~o_empty;
  assign do_push_s = i_push & (~o_full | do_pop_s);
  assign o_data    = mem_q[rd_q];

  // Next pointers and occupancy.
  always_comb begin
    wr_d  = do_push_s ? wr_q + AW'(1) : wr_q;
    rd_d  = do_pop_s  ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q;
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage, pointers and occupancy registers; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_q] <= i_data;
      end
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/orient_kp_scheduler.sv
// Sequencer for the free-running 7x7 orientation unit.
// Ports: i_clk, i_rst_n (async active-low), bus (slave modport):
//   column stream in -> o_col to the unit; keypoints tagged with their window
//   centre (x-3, y-3), delayed ORI_LAT cycles to meet i_cos/i_sin, then pushed
//   into a FWFT FIFO popped by the descriptor stage (o_valid & i_ready).
//   o_drop_cnt counts keypoints lost to a full FIFO (saturating).
module orient_kp_scheduler
  import orient_kp_scheduler_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  orient_kp_scheduler_if.slave  bus
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);

  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  tag_t               tag_d;
  tag_t               dly_q [ORI_LAT];
  tag_t               tag_out_s;
  entry_t             fifo_in_s;
  entry_t             fifo_head_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic               pop_s;

  // The unit clocks every cycle, so idle cycles must present a zero column.
  assign bus.o_col = (bus.i_valid & i_rst_n) ? bus.i_col : '0;

  // Coordinates and run length of the current column (x_d/y_d/run_d include it).
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    run_d = '0;
    if (bus.i_valid) begin
      if (bus.i_sof) begin
        x_d   = '0;
        y_d   = '0;
        run_d = 3'd1;
      end else begin
        run_d = run_inc(run_q);
        if (x_q == X_LAST) begin
          x_d = '0;
          y_d = (y_q == Y_LAST) ? y_q : y_q + 10'd1;
        end else begin
          x_d = x_q + 10'd1;
          y_d = y_q;
        end
      end
    end else begin
      run_d = '0;
    end
  end

  // Tag gate: only keypoints whose full 7x7 window has been streamed are forwarded.
  always_comb begin
    tag_d = '0;
    if (bus.i_valid && bus.i_kp && (run_d == RUN_FULL) &&
        (x_d >= WIN_MIN) && (y_d >= WIN_MIN)) begin
      tag_d.v = 1'b1;
      tag_d.x = x_d - WIN_HALF;
      tag_d.y = y_d - WIN_HALF;
    end else begin
      tag_d = '0;
    end
  end

  assign tag_out_s       = dly_q[ORI_LAT-1];
  assign pop_s           = ~fifo_empty_s & bus.i_ready;
  assign fifo_in_s.x     = tag_out_s.x;
  assign fifo_in_s.y     = tag_out_s.y;
  assign fifo_in_s.cos_v = bus.i_cos;
  assign fifo_in_s.sin_v = bus.i_sin;

  // Drop count: a tag exiting into a full FIFO with no pop this cycle is lost.
  always_comb begin
    if (tag_out_s.v && fifo_full_s && !pop_s && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  // Counter, run-length, delay-line and drop-count registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      run_q  <= '0;
      drop_q <= '0;
      for (int k = 0; k < ORI_LAT; k++) begin
        dly_q[k] <= '0;
      end
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      run_q  <= run_d;
      drop_q <= drop_d;
      dly_q[0] <= tag_d;
      for (int k = 1; k < ORI_LAT; k++) begin
        dly_q[k] <= dly_q[k-1];
      end
    end
  end

  kp_sync_fifo #(
    .W     (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (tag_out_s.v),
    .i_data  (fifo_in_s),
    .i_pop   (pop_s),
    .o_data  (fifo_head_s),
    .o_full  (fifo_full_s),
    .o_empty (fifo_empty_s)
  );

  assign bus.o_valid    = ~fifo_empty_s;
  assign bus.o_x        = fifo_head_s.x;
  assign bus.o_y        = fifo_head_s.y;
  assign bus.o_cos      = fifo_head_s.cos_v;
  assign bus.o_sin      = fifo_head_s.sin_v;
  assign bus.o_drop_cnt = drop_q;

endmodule

// File: tb/tb_orient_kp_scheduler.sv
// Directed bench for orient_kp_scheduler with a behavioural orientation unit
// (7-cycle pipeline of o_col) and a scoreboard of expected FIFO entries.
module tb_orient_kp_scheduler;
  import orient_kp_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  orient_kp_scheduler_if bus();

  orient_kp_scheduler #(.WIDTH(640), .HEIGHT(480)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  function automatic logic [11:0] cos_of(input logic [55:0] c);
    return c[11:0] ^ c[55:44];
  endfunction

  function automatic logic [11:0] sin_of(input logic [55:0] c);
    return c[23:12] + c[43:32];
  endfunction

  // Orientation unit model: answers for the column seen 7 clocks earlier.
  logic [6:0][55:0] pipe = '0;
  always @(posedge clk) pipe <= {pipe[5:0], bus.o_col};
  assign bus.i_cos = cos_of(pipe[6]);
  assign bus.i_sin = sin_of(pipe[6]);

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          kp_cyc = -1;
  int          first_v_cyc = -1;
  bit          lat_pending = 1'b0;
  entry_t      exp_q[$];
  logic [55:0] exp_col;
  bit          kp_map[640];
  bit          exp_map[640];
  bit          rdy_map[640];
  bit          use_rdy_map = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic rnd_col(output logic [55:0] col);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    col = r[55:0];
  endtask

  task automatic drive(input bit v, input bit sof, input bit kp, input logic [55:0] col);
    bus.i_valid = v;
    bus.i_sof   = sof;
    bus.i_kp    = kp;
    bus.i_col   = col;
    exp_col     = (rst_n && v) ? col : 56'd0;
  endtask

  task automatic drive_idle();
    logic [55:0] col;
    rnd_col(col);
    drive(1'b0, 1'b0, 1'b0, col);
  endtask

  // One clock: sample away from the edge, score any pop, then step past the edge.
  task automatic tick();
    entry_t got;
    entry_t e;
    @(negedge clk);
    chk("o_col", 64'(bus.o_col), 64'(exp_col));
    if (first_v_cyc < 0 && kp_cyc >= 0 && bus.o_valid) first_v_cyc = cyc;
    if (bus.o_valid && bus.i_ready) begin
      got.x = bus.o_x;
      got.y = bus.o_y;
      got.cos_v = bus.o_cos;
      got.sin_v = bus.o_sin;
      if (exp_q.size() == 0) begin
        chk("spurious_pop", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("pop_entry", 64'(got), 64'(e));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_maps();
    for (int i = 0; i < 640; i++) begin
      kp_map[i] = 1'b0;
      exp_map[i] = 1'b0;
      rdy_map[i] = 1'b0;
    end
  endtask

  // Stream one row of continuous valid columns (optionally one idle gap before gap_x).
  task automatic send_row(input int y, input bit sof_first, input int x_stop, input int gap_x);
    logic [55:0] col;
    entry_t e;
    for (int x = 0; x <= x_stop; x++) begin
      if (x == gap_x) begin
        drive_idle();
        tick();
      end
      rnd_col(col);
      if (use_rdy_map) bus.i_ready = rdy_map[x];
      drive(1'b1, sof_first && (x == 0), kp_map[x], col);
      if (kp_map[x] && exp_map[x]) begin
        e.x = 10'(x - 3);
        e.y = 10'(y - 3);
        e.cos_v = cos_of(col);
        e.sin_v = sin_of(col);
        exp_q.push_back(e);
      end
      if (lat_pending && kp_map[x]) begin
        kp_cyc = cyc;
        lat_pending = 1'b0;
      end
      tick();
    end
    drive_idle();
  endtask

  initial begin
    logic [55:0] col;
    // Reset held with stimulus toggling.
    rst_n = 1'b0;
    bus.i_ready = 1'b1;
    drive_idle();
    for (int i = 0; i < 6; i++) begin
      rnd_col(col);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), col);
      tick();
    end
    chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_o_x", 64'(bus.o_x), 64'd0);
    chk("rst_o_y", 64'(bus.o_y), 64'd0);
    chk("rst_o_cos", 64'(bus.o_cos), 64'd0);
    chk("rst_o_sin", 64'(bus.o_sin), 64'd0);
    chk("rst_drop", 64'(bus.o_drop_cnt), 64'd0);
    rst_n = 1'b1;
    drive_idle();
    ticks(2);

    // Frame A: latency, gating and row wrap.
    for (int y = 0; y < 10; y++) begin
      clear_maps();
      if (y < 6) kp_map[100] = 1'b1;
      if (y == 6) begin
        kp_map[10] = 1'b1; exp_map[10] = 1'b1; lat_pending = 1'b1;
      end
      if (y == 7) begin
        kp_map[3] = 1'b1; kp_map[639] = 1'b1; exp_map[639] = 1'b1;
      end
      if (y == 8) begin
        kp_map[5] = 1'b1; kp_map[6] = 1'b1; exp_map[6] = 1'b1;
      end
      if (y == 9) begin
        kp_map[5] = 1'b1; kp_map[24] = 1'b1; kp_map[26] = 1'b1; exp_map[26] = 1'b1;
      end
      send_row(y, y == 0, 639, (y == 9) ? 20 : -1);
    end
    ticks(12);
    chk("latency", 64'(first_v_cyc - kp_cyc), 64'd8);
    chk("sb_empty_A", 64'(exp_q.size()), 64'd0);
    chk("idle_valid_A", 64'(bus.o_valid), 64'd0);
    chk("drop_A", 64'(bus.o_drop_cnt), 64'd0);

    // Frame B: backpressure with 6 keypoints into a 4-deep FIFO.
    clear_maps();
    bus.i_ready = 1'b1;
    for (int y = 0; y < 6; y++) send_row(y, y == 0, 639, -1);
    for (int x = 10; x < 16; x++) begin
      kp_map[x] = 1'b1; exp_map[x] = 1'b1;
    end
    bus.i_ready = 1'b0;
    send_row(6, 1'b0, 639, -1);
    ticks(3);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    chk("bp_drop", 64'(bus.o_drop_cnt), 64'd2);
    chk("bp_valid_held", 64'(bus.o_valid), 64'd1);
    chk("bp_head_x", 64'(bus.o_x), 64'd7);
    bus.i_ready = 1'b1;
    ticks(4);
    chk("bp_valid_after4", 64'(bus.o_valid), 64'd0);
    chk("sb_empty_bp", 64'(exp_q.size()), 64'd0);

    // Full FIFO with a pop in the same cycle a tag exits.
    clear_maps();
    for (int x = 10; x < 14; x++) begin
      kp_map[x] = 1'b1; exp_map[x] = 1'b1;
    end
    kp_map[20] = 1'b1; exp_map[20] = 1'b1;
    rdy_map[27] = 1'b1;
    use_rdy_map = 1'b1;
    send_row(7, 1'b0, 639, -1);
    use_rdy_map = 1'b0;
    bus.i_ready = 1'b0;
    ticks(3);
    chk("fp_drop", 64'(bus.o_drop_cnt), 64'd2);
    chk("fp_valid", 64'(bus.o_valid), 64'd1);
    bus.i_ready = 1'b1;
    ticks(4);
    chk("fp_valid_after4", 64'(bus.o_valid), 64'd0);
    chk("sb_empty_fp", 64'(exp_q.size()), 64'd0);

    // Reset with three tags in flight.
    clear_maps();
    for (int x = 10; x < 13; x++) kp_map[x] = 1'b1;
    send_row(8, 1'b0, 13, -1);
    rst_n = 1'b0;
    drive_idle();
    exp_q.delete();
    ticks(3);
    chk("mid_rst_drop", 64'(bus.o_drop_cnt), 64'd0);
    rst_n = 1'b1;
    drive_idle();
    ticks(15);
    chk("post_rst_valid", 64'(bus.o_valid), 64'd0);
    chk("post_rst_drop", 64'(bus.o_drop_cnt), 64'd0);

    // Frame C: smallest accepted centre after reset.
    clear_maps();
    for (int y = 0; y < 6; y++) send_row(y, y == 0, 639, -1);
    kp_map[5] = 1'b1;
    kp_map[6] = 1'b1; exp_map[6] = 1'b1;
    send_row(6, 1'b0, 40, -1);
    ticks(12);
    chk("sb_empty_C", 64'(exp_q.size()), 64'd0);
    chk("idle_valid_C", 64'(bus.o_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
